// File: rtl/ex.sv
// ex : execute stage of the five-stage pipeline.
// Logic, shift and add/sub/compare results are produced combinationally.
// Signed/unsigned divide uses an iterative radix-2 restoring divider that
// holds the upstream stages through stallreq while it runs.
// Optional feature macro: EX_DIV_EN. When it is undefined the divider is
// absent, the divide class behaves as nop and the HI/LO outputs are tied to 0.
module ex (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic [2:0]  alusel_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        stallreq
);

   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;
   localparam logic [2:0] SEL_ARITH = 3'b011;
   localparam logic [2:0] SEL_DIV   = 3'b100;

   localparam logic [7:0] OP_AND = 8'h24;
   localparam logic [7:0] OP_OR  = 8'h25;
   localparam logic [7:0] OP_XOR = 8'h26;
   localparam logic [7:0] OP_NOR = 8'h27;
   localparam logic [7:0] OP_SLL = 8'h7C;
   localparam logic [7:0] OP_SRL = 8'h02;
   localparam logic [7:0] OP_SRA = 8'h03;
   localparam logic [7:0] OP_ADD = 8'h21;
   localparam logic [7:0] OP_SUB = 8'h23;
   localparam logic [7:0] OP_SLT = 8'h2A;

   logic [31:0] alu_result;

   // Single-cycle result for logic, shift and arith classes; 0 for anything else
   always_comb begin
      alu_result = 32'h0;
      case (alusel_i)
         SEL_LOGIC: begin
            case (aluop_i)
               OP_OR:   alu_result = reg1_i | reg2_i;
               OP_AND:  alu_result = reg1_i & reg2_i;
               OP_XOR:  alu_result = reg1_i ^ reg2_i;
               OP_NOR:  alu_result = ~(reg1_i | reg2_i);
               default: alu_result = 32'h0;
            endcase
         end
         SEL_SHIFT: begin
            case (aluop_i)
               OP_SLL:  alu_result = reg2_i << reg1_i[4:0];
               OP_SRL:  alu_result = reg2_i >> reg1_i[4:0];
               OP_SRA:  alu_result = $signed(reg2_i) >>> reg1_i[4:0];
               default: alu_result = 32'h0;
            endcase
         end
         SEL_ARITH: begin
            case (aluop_i)
               OP_ADD:  alu_result = reg1_i + reg2_i;
               OP_SUB:  alu_result = reg1_i - reg2_i;
               OP_SLT:  alu_result = {31'h0, ($signed(reg1_i) < $signed(reg2_i))};
               default: alu_result = 32'h0;
            endcase
         end
         default: alu_result = 32'h0;
      endcase
   end

`ifdef EX_DIV_EN

   localparam logic [7:0] OP_DIV  = 8'h1A;
   localparam logic [7:0] OP_DIVU = 8'h1B;

   typedef enum logic [1:0] {IDLE, DIV_ON, BYZERO, DIV_END} div_state_t;

   div_state_t  state, next_state;
   logic [5:0]  cnt;
   logic [31:0] divisor;
   logic [31:0] quo;
   logic [31:0] rem;
   logic        sign_q;
   logic        sign_r;

   logic        is_div_class;
   logic        div_start;
   logic        signed_div;
   logic [31:0] mag1;
   logic [31:0] mag2;
   logic [32:0] trial;
   logic [32:0] trial_sub;
   logic        take;

   assign is_div_class = (alusel_i == SEL_DIV);
   assign div_start    = is_div_class && ((aluop_i == OP_DIV) || (aluop_i == OP_DIVU));
   assign signed_div   = (aluop_i == OP_DIV);
   assign mag1         = (signed_div && reg1_i[31]) ? (32'h0 - reg1_i) : reg1_i;
   assign mag2         = (signed_div && reg2_i[31]) ? (32'h0 - reg2_i) : reg2_i;

   // The quotient register doubles as the dividend shifter: each step moves
   // its top bit into the partial remainder and shifts a quotient bit in below.
   assign trial     = {rem, quo[31]};
   assign trial_sub = trial - {1'b0, divisor};
   assign take      = (trial >= {1'b0, divisor});

   // Divider state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // Divider datapath: operand capture at start, one restoring step per cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= 6'd0;
         divisor <= 32'h0;
         quo     <= 32'h0;
         rem     <= 32'h0;
         sign_q  <= 1'b0;
         sign_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (div_start) begin
                  cnt     <= 6'd0;
                  divisor <= mag2;
                  quo     <= mag1;
                  rem     <= 32'h0;
                  sign_q  <= signed_div & (reg1_i[31] ^ reg2_i[31]);
                  sign_r  <= signed_div & reg1_i[31];
               end
            end
            DIV_ON: begin
               rem <= take ? trial_sub[31:0] : trial[31:0];
               quo <= {quo[30:0], take};
               cnt <= cnt + 6'd1;
            end
            BYZERO: begin
               rem <= quo;
               quo <= 32'h0;
            end
            default: ;
         endcase
      end
   end

   // Divider next-state selection
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (div_start) next_state = (reg2_i == 32'h0) ? BYZERO : DIV_ON;
         end
         DIV_ON:  if (cnt == 6'd31) next_state = DIV_END;
         BYZERO:  next_state = DIV_END;
         DIV_END: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Stage outputs; everything is forced to 0 while reset is asserted
   always_comb begin
      wd_o     = 5'd0;
      wreg_o   = 1'b0;
      wdata_o  = 32'h0;
      whilo_o  = 1'b0;
      hi_o     = 32'h0;
      lo_o     = 32'h0;
      stallreq = 1'b0;
      if (rst) begin
         wd_o = wd_i;
         if (!is_div_class) begin
            wreg_o  = wreg_i;
            wdata_o = alu_result;
         end
         stallreq = ((state == IDLE) && div_start) || (state == DIV_ON) || (state == BYZERO);
         if (state == DIV_END) begin
            whilo_o = 1'b1;
            lo_o    = sign_q ? (32'h0 - quo) : quo;
            hi_o    = sign_r ? (32'h0 - rem) : rem;
         end
      end
   end

`else

   logic unused_clk;
   assign unused_clk = clk;

   // Stage outputs without a divider; divide class falls through as nop
   always_comb begin
      wd_o     = 5'd0;
      wreg_o   = 1'b0;
      wdata_o  = 32'h0;
      whilo_o  = 1'b0;
      hi_o     = 32'h0;
      lo_o     = 32'h0;
      stallreq = 1'b0;
      if (rst) begin
         wd_o    = wd_i;
         wreg_o  = wreg_i;
         wdata_o = (alusel_i == SEL_DIV) ? 32'h0 : alu_result;
      end
   end

`endif

endmodule

// File: tb/tb_ex.sv
// tb_ex : directed self-checking bench for the ex execute stage.
// Divider scenarios are exercised when EX_DIV_EN is defined; otherwise the
// divide class is checked to behave as nop.
module tb_ex;

   logic        clk;
   logic        rst;
   logic [7:0]  aluop_i;
   logic [2:0]  alusel_i;
   logic [31:0] reg1_i;
   logic [31:0] reg2_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        whilo_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        stallreq;

   int checks = 0;
   int errors = 0;

   ex dut (
      .clk      (clk),
      .rst      (rst),
      .aluop_i  (aluop_i),
      .alusel_i (alusel_i),
      .reg1_i   (reg1_i),
      .reg2_i   (reg2_i),
      .wd_i     (wd_i),
      .wreg_i   (wreg_i),
      .wd_o     (wd_o),
      .wreg_o   (wreg_o),
      .wdata_o  (wdata_o),
      .whilo_o  (whilo_o),
      .hi_o     (hi_o),
      .lo_o     (lo_o),
      .stallreq (stallreq)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic w);
      aluop_i  = op;
      alusel_i = sel;
      reg1_i   = a;
      reg2_i   = b;
      wd_i     = wd;
      wreg_i   = w;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      drive(8'h25, 3'b001, 32'hFFFF_0000, 32'h0000_FFFF, 5'd7, 1'b1);
      #12;
      checks++; if (wdata_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected %h", wdata_o, 32'h0); end
      checks++; if (wd_o !== 5'd0) begin errors++; $display("[TB] FAIL reset_wd: got %0d expected 0", wd_o); end
      checks++; if (wreg_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_wreg: got %b expected 0", wreg_o); end
      checks++; if ({whilo_o, stallreq} !== 2'b00) begin errors++; $display("[TB] FAIL reset_whilo_stall: got %b expected 00", {whilo_o, stallreq}); end
      checks++; if ({hi_o, lo_o} !== 64'h0) begin errors++; $display("[TB] FAIL reset_hilo: got %h expected 0", {hi_o, lo_o}); end
      @(negedge clk);
      rst = 1'b1;
      drive(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_single_cycle;
      logic [7:0]  ops  [13] = '{8'h25, 8'h24, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03,
                                 8'h21, 8'h23, 8'h2A, 8'h2A, 8'h99, 8'h21};
      logic [2:0]  sels [13] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010,
                                 3'b011, 3'b011, 3'b011, 3'b011, 3'b001, 3'b000};
      logic [31:0] as   [13] = '{32'hF0F0_0000, 32'hF0F0_FF00, 32'hF0F0_FF00, 32'h0000_0000,
                                 32'h0000_0004, 32'h0000_0004, 32'h0000_0004,
                                 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001,
                                 32'h1234_5678, 32'h0000_0005};
      logic [31:0] bs   [13] = '{32'h0000_0F0F, 32'h0FF0_F0F0, 32'h0FF0_F0F0, 32'h0000_0000,
                                 32'h0000_0001, 32'h8000_0000, 32'h8000_0000,
                                 32'h0000_0002, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFF,
                                 32'h1111_1111, 32'h0000_0006};
      logic [31:0] exps [13] = '{32'hF0F0_0F0F, 32'h00F0_F000, 32'hFF00_0FF0, 32'hFFFF_FFFF,
                                 32'h0000_0010, 32'h0800_0000, 32'hF800_0000,
                                 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000,
                                 32'h0000_0000, 32'h0000_0000};
      for (int i = 0; i < 13; i++) begin
         drive(ops[i], sels[i], as[i], bs[i], 5'(i + 5), i[0] ? 1'b0 : 1'b1);
         @(negedge clk);
         checks++; if (wdata_o !== exps[i]) begin errors++; $display("[TB] FAIL op%0d_wdata: got %h expected %h", i, wdata_o, exps[i]); end
         checks++; if (wd_o !== 5'(i + 5)) begin errors++; $display("[TB] FAIL op%0d_wd: got %0d expected %0d", i, wd_o, i + 5); end
         checks++; if (wreg_o !== (i[0] ? 1'b0 : 1'b1)) begin errors++; $display("[TB] FAIL op%0d_wreg: got %b expected %b", i, wreg_o, ~i[0]); end
         checks++; if ({stallreq, whilo_o} !== 2'b00) begin errors++; $display("[TB] FAIL op%0d_stall_whilo: got %b expected 00", i, {stallreq, whilo_o}); end
      end
   endtask

`ifdef EX_DIV_EN

   // Starts a divide at the next rising edge and counts stalled cycles until
   // stallreq drops; returns at the falling edge of the result cycle.
   task automatic run_div(input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int stalls);
      bit done;
      @(posedge clk);
      #1 drive(op, 3'b100, a, b, 5'd3, 1'b1);
      stalls = 0;
      done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         if (stallreq) stalls++;
         else done = 1'b1;
      end
   endtask

   task automatic go_nop;
      @(posedge clk);
      #1 drive(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
      @(negedge clk);
      checks++; if ({whilo_o, hi_o, lo_o} !== 65'h0) begin errors++; $display("[TB] FAIL after_div_idle: got whilo=%b hi=%h lo=%h expected all 0", whilo_o, hi_o, lo_o); end
   endtask

   task automatic test_div_signed;
      int stalls;
      run_div(8'h1A, 32'hFFFF_FFF9, 32'h0000_0002, stalls);
      checks++; if (stalls !== 33) begin errors++; $display("[TB] FAIL div_stalls: got %0d expected 33", stalls); end
      checks++; if (whilo_o !== 1'b1) begin errors++; $display("[TB] FAIL div_whilo: got %b expected 1", whilo_o); end
      checks++; if (lo_o !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_lo: got %h expected fffffffd", lo_o); end
      checks++; if (hi_o !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_hi: got %h expected ffffffff", hi_o); end
      checks++; if ({wreg_o, wdata_o} !== 33'h0) begin errors++; $display("[TB] FAIL div_wreg_wdata: got %b/%h expected 0/0", wreg_o, wdata_o); end
      go_nop();
   endtask

   task automatic test_divu;
      int stalls;
      run_div(8'h1B, 32'hFFFF_FFFF, 32'h0000_0010, stalls);
      checks++; if (stalls !== 33) begin errors++; $display("[TB] FAIL divu_stalls: got %0d expected 33", stalls); end
      checks++; if (lo_o !== 32'h0FFF_FFFF) begin errors++; $display("[TB] FAIL divu_lo: got %h expected 0fffffff", lo_o); end
      checks++; if (hi_o !== 32'h0000_000F) begin errors++; $display("[TB] FAIL divu_hi: got %h expected 0000000f", hi_o); end
      go_nop();
   endtask

   task automatic test_div_zero;
      int stalls;
      run_div(8'h1A, 32'd100, 32'h0, stalls);
      checks++; if (stalls !== 2) begin errors++; $display("[TB] FAIL divzero_stalls: got %0d expected 2", stalls); end
      checks++; if (whilo_o !== 1'b1) begin errors++; $display("[TB] FAIL divzero_whilo: got %b expected 1", whilo_o); end
      checks++; if (lo_o !== 32'h0) begin errors++; $display("[TB] FAIL divzero_lo: got %h expected 0", lo_o); end
      checks++; if (hi_o !== 32'd100) begin errors++; $display("[TB] FAIL divzero_hi: got %h expected 00000064", hi_o); end
      go_nop();
   endtask

   task automatic test_back_to_back;
      int stalls;
      run_div(8'h1A, 32'd20, 32'hFFFF_FFFD, stalls);
      checks++; if (stalls !== 33) begin errors++; $display("[TB] FAIL b2b1_stalls: got %0d expected 33", stalls); end
      checks++; if ({hi_o, lo_o} !== {32'h0000_0002, 32'hFFFF_FFFA}) begin errors++; $display("[TB] FAIL b2b1_hilo: got %h/%h expected 00000002/fffffffa", hi_o, lo_o); end
      run_div(8'h1B, 32'd100, 32'd7, stalls);
      checks++; if (stalls !== 33) begin errors++; $display("[TB] FAIL b2b2_stalls: got %0d expected 33", stalls); end
      checks++; if ({hi_o, lo_o} !== {32'd2, 32'd14}) begin errors++; $display("[TB] FAIL b2b2_hilo: got %h/%h expected 00000002/0000000e", hi_o, lo_o); end
      go_nop();
   endtask

   task automatic test_reset_mid_div;
      int stalls;
      @(posedge clk);
      #1 drive(8'h1B, 3'b100, 32'hFFFF_FFFF, 32'h0000_0010, 5'd9, 1'b1);
      stalls = 0;
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         if (stallreq) stalls++;
      end
      checks++; if (stalls !== 11) begin errors++; $display("[TB] FAIL middiv_stalls: got %0d expected 11", stalls); end
      rst = 1'b0;
      #1;
      checks++; if (stallreq !== 1'b0) begin errors++; $display("[TB] FAIL middiv_stall: got %b expected 0", stallreq); end
      checks++; if ({wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o} !== 103'h0) begin errors++; $display("[TB] FAIL middiv_outputs: got wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h expected all 0", wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o); end
      drive(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      run_div(8'h1A, 32'd9, 32'd3, stalls);
      checks++; if (stalls !== 33) begin errors++; $display("[TB] FAIL postrst_stalls: got %0d expected 33", stalls); end
      checks++; if ({hi_o, lo_o} !== {32'd0, 32'd3}) begin errors++; $display("[TB] FAIL postrst_hilo: got %h/%h expected 00000000/00000003", hi_o, lo_o); end
      go_nop();
   endtask

`else

   task automatic test_div_disabled;
      drive(8'h1A, 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 1'b1);
      @(negedge clk);
      checks++; if (wreg_o !== 1'b1) begin errors++; $display("[TB] FAIL nodiv_wreg: got %b expected 1", wreg_o); end
      checks++; if (wd_o !== 5'd11) begin errors++; $display("[TB] FAIL nodiv_wd: got %0d expected 11", wd_o); end
      checks++; if (wdata_o !== 32'h0) begin errors++; $display("[TB] FAIL nodiv_wdata: got %h expected 0", wdata_o); end
      checks++; if ({stallreq, whilo_o} !== 2'b00) begin errors++; $display("[TB] FAIL nodiv_stall_whilo: got %b expected 00", {stallreq, whilo_o}); end
      @(negedge clk);
      checks++; if ({hi_o, lo_o, stallreq} !== 65'h0) begin errors++; $display("[TB] FAIL nodiv_hilo: got %h/%h stall=%b expected 0", hi_o, lo_o, stallreq); end
      drive(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
   endtask

`endif

   // Scenario sequence
   initial begin
      drive(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
      test_reset();
      test_single_cycle();
`ifdef EX_DIV_EN
      test_div_signed();
      test_divu();
      test_div_zero();
      test_back_to_back();
      test_reset_mid_div();
`else
      test_div_disabled();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex.md
# ex

Execute stage of the five-stage pipeline. Consumes the registered decode outputs (ALU opcode, ALU class, two operands, destination index, write enable) and produces the writeback result for the EX/MEM register. Logic, shift and add/sub/compare operations complete combinationally in the same cycle. Signed and unsigned divide run on an iterative radix-2 divider FSM that holds the pipeline through `stallreq`.

## Interface
Parameters:
- none. Widths are fixed: 32-bit data, 5-bit register index, 8-bit aluop, 3-bit alusel.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low. Low immediately clears all state and outputs.
- `aluop_i` in 8: operation code from ID/EX.
- `alusel_i` in 3: operation class from ID/EX.
- `reg1_i` in 32: operand 1, and shift amount in `[4:0]`.
- `reg2_i` in 32: operand 2, and the value being shifted.
- `wd_i` in 5: destination register index.
- `wreg_i` in 1: destination write enable.
- `wd_o` out 5: destination index, passed through.
- `wreg_o` out 1: register write enable.
- `wdata_o` out 32: result.
- `whilo_o` out 1: HI/LO write strobe. Divide only.
- `hi_o` out 32: remainder.
- `lo_o` out 32: quotient.
- `stallreq` out 1: hold the upstream stages. ID/EX keeps its inputs stable while this is high.

## Operation
- alusel encodings:
  - 000: nop.
  - 001: logic. OR=8'h25, AND=8'h24, XOR=8'h26, NOR=8'h27.
  - 010: shift. SLL=8'h7C, SRL=8'h02, SRA=8'h03.
  - 011: arith. ADD=8'h21, SUB=8'h23, SLT=8'h2A.
  - 100: divide. DIV=8'h1A, DIVU=8'h1B.
- Arithmetic rules:
  - Add and subtract are 32-bit modulo. No overflow trap.
  - SLT is a signed compare. It produces 1 or 0.
  - Shifts use `reg1_i[4:0]` applied to `reg2_i`. SRA replicates bit 31.
- Non-divide operations:
  - `wd_o = wd_i`, `wreg_o = wreg_i`, `whilo_o = 0`.
  - `wdata_o` is 0 for nop and for any unknown aluop.
- Divide: `wreg_o = 0`, `wdata_o = 0`. The result goes only to HI/LO. Divider FSM states:
  - IDLE
    - Divide class with divisor ≠ 0: latch the operand magnitudes and the sign flags (DIV only), clear the 6-bit counter, go to DIV_ON.
    - Divisor = 0: go to BYZERO.
    - `stallreq = 1` combinationally in this cycle.
  - DIV_ON
    - One restoring shift/subtract step per cycle, 32 steps. Counter 0..31.
    - Go to DIV_END after step 31. `stallreq = 1`.
  - BYZERO
    - Quotient = 0, remainder = dividend. Go to DIV_END. `stallreq = 1`.
  - DIV_END
    - `stallreq = 0`, `whilo_o = 1`, result registers drive `lo_o`/`hi_o`.
    - DIV sign fix-up: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
    - Go to IDLE unconditionally.
- The next instruction loads into ID/EX at the DIV_END edge. Back-to-back divides therefore restart from IDLE.
- `hi_o`/`lo_o` are 0 whenever `whilo_o = 0`.
- Reset mid-divide: FSM goes to IDLE, datapath registers clear, `stallreq` drops at once.

## Timing
- Reset values of all outputs: 0.
- Logic, shift and arith: 0-cycle latency, no stall.
- Divide with nonzero divisor:
  - Detect cycle C0 (IDLE): stall.
  - C1–C32 (DIV_ON): stall.
  - C33 (DIV_END): result valid, stall low.
  - Total: 33 stalled cycles.
- Divide by zero: C0 IDLE stall, C1 BYZERO stall, C2 DIV_END. Two stalled cycles.
- Operands are sampled only at C0. Input changes during DIV_ON are ignored.

## Configuration
- `EX_DIV_EN` defined: divider FSM and HI/LO outputs are present as specified above.
- `EX_DIV_EN` undefined:
  - Divide class is treated as nop: `wreg_o = wreg_i`, `wdata_o = 0`.
  - `stallreq`, `whilo_o`, `hi_o` and `lo_o` are tied to 0.
  - No FSM is instantiated.

## Test plan
- OR, reg1=32'hF0F0_0000, reg2=32'h0000_0F0F, wd=5, wreg=1 -> same cycle: wdata=32'hF0F0_0F0F, wd_o=5, wreg_o=1, stallreq=0.
- SRA, reg1=4, reg2=32'h8000_0000 -> wdata=32'hF800_0000. SLT, reg1=32'hFFFF_FFFF, reg2=1 -> wdata=1.
- DIV, reg1=-7, reg2=2 -> stallreq high for exactly 33 cycles. At DIV_END: whilo_o=1, lo_o=32'hFFFF_FFFD (-3), hi_o=32'hFFFF_FFFF (-1), wreg_o=0.
- DIVU, reg1=32'hFFFF_FFFF, reg2=16 -> lo_o=32'h0FFF_FFFF, hi_o=15 after 33 stalled cycles.
- DIV by zero, reg1=100 -> stall for 2 cycles, then lo_o=0, hi_o=100, whilo_o=1.
- Assert rst low at step 10 of DIVU -> all outputs 0 and stallreq=0 immediately. After release, a new DIV 9/3 gives lo_o=3, hi_o=0.
